gate_vector_checker: RTL and testbench

//  Synthesizable exhaustive-vector tester for small combinational gates (and4gate and kin).

---
 rtl/gate_test_pkg.sv | 35 +++
 rtl/gate_ref_model.sv | 23 ++
 rtl/gate_vector_checker.sv | 135 +++++++++++++
 tb/tb_gate_vector_checker.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/gate_test_pkg.sv
// Shared types and the golden reduction used by the gate-lab vector checkers.
package gate_test_pkg;

   typedef enum logic [1:0] {IDLE, WAIT, SAMPLE, DONE} state_e;

   typedef enum int {OP_AND, OP_OR, OP_XOR, OP_NAND, OP_NOR} op_e;

   localparam int MAX_N = 32;

   // Reduces the low n bits of vec; bits at and above n are ignored.
   function automatic logic golden(input op_e op, input logic [MAX_N-1:0] vec, input int n);
      logic r_and;
      logic r_or;
      logic r_xor;
      r_and = 1'b1;
      r_or  = 1'b0;
      r_xor = 1'b0;
      for (int i = 0; i < MAX_N; i++) begin
         if (i < n) begin
            r_and = r_and & vec[i];
            r_or  = r_or | vec[i];
            r_xor = r_xor ^ vec[i];
         end
      end
      case (op)
         OP_AND:  golden = r_and;
         OP_OR:   golden = r_or;
         OP_XOR:  golden = r_xor;
         OP_NAND: golden = ~r_and;
         OP_NOR:  golden = ~r_or;
         default: golden = r_and;
      endcase
   endfunction

endpackage

// File: rtl/gate_ref_model.sv
// Combinational golden output for an N-input gate; shared by the lab checkers.
module gate_ref_model
   import gate_test_pkg::*;
#(
   parameter int N  = 4,
   parameter int OP = 0
) (
   input  logic [N-1:0] vec_i,
   output logic         f_o
);

   if (OP < 0 || OP > 4) begin : g_bad_op
      $error("gate_ref_model: OP=%0d is not a supported gate function", OP);
   end
   if (N < 1 || N > MAX_N) begin : g_bad_n
      $error("gate_ref_model: N=%0d out of range", N);
   end

   always_comb begin
      f_o = golden(op_e'(OP), MAX_N'(vec_i), N);
   end

endmodule

// File: rtl/gate_vector_checker.sv
// Exhaustive vector tester: walks all 2^N inputs of a gate DUT and counts mismatches.
//   state  | meaning
//   IDLE   | after reset, waiting for start
//   WAIT   | vector driven, letting the DUT settle (SETTLE+1 cycles)
//   SAMPLE | compare dut_f_i against golden, advance or finish
//   DONE   | results held until the next start
module gate_vector_checker
   import gate_test_pkg::*;
#(
   parameter int N      = 4,
   parameter int SETTLE = 1,
   parameter int OP     = 0
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   output logic [N-1:0] vec_o,
   input  logic         dut_f_i,
   output logic         busy,
   output logic         done,
   output logic         pass,
   output logic         sample_valid,
   output logic [N:0]   err_count,
   output logic         fail_seen,
   output logic [N-1:0] first_fail_vec
);

   localparam int            WW       = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
   localparam logic [WW-1:0] SETTLE_W = WW'(SETTLE);
   localparam logic [WW-1:0] WAIT_ONE = WW'(1);
   localparam logic [N:0]    ERR_ONE  = {{N{1'b0}}, 1'b1};
   localparam logic [N-1:0]  VEC_ONE  = {{(N-1){1'b0}}, 1'b1};

   state_e        state_q, state_d;
   logic [WW-1:0] wait_q, wait_d;
   logic [N-1:0]  vec_q, vec_d;
   logic [N-1:0]  ffv_q, ffv_d;
   logic [N:0]    err_q, err_d;
   logic          fail_q, fail_d;
   logic          pass_q, pass_d;
   logic          exp_f;
   logic          mismatch;
   logic          last_vec;
   logic          launch;

   gate_ref_model #(.N(N), .OP(OP)) u_ref (
      .vec_i (vec_q),
      .f_o   (exp_f)
   );

   // X or Z from the DUT must count as a failure, hence the case inequality.
   assign mismatch = (dut_f_i !== exp_f);
   assign last_vec = (vec_q == {N{1'b1}});
   assign launch   = start && ((state_q == IDLE) || (state_q == DONE));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE, DONE: if (start) state_d = WAIT;
         WAIT:       if (wait_q == '0) state_d = SAMPLE;
         SAMPLE:     state_d = last_vec ? DONE : WAIT;
         default:    state_d = IDLE;
      endcase
   end

   always_comb begin
      busy         = (state_q == WAIT) || (state_q == SAMPLE);
      done         = (state_q == DONE);
      sample_valid = (state_q == SAMPLE);
   end

   always_comb begin
      wait_d = wait_q;
      vec_d  = vec_q;
      ffv_d  = ffv_q;
      err_d  = err_q;
      fail_d = fail_q;
      pass_d = pass_q;
      if (launch) begin
         wait_d = SETTLE_W;
         vec_d  = '0;
         ffv_d  = '0;
         err_d  = '0;
         fail_d = 1'b0;
         pass_d = 1'b0;
      end else if (state_q == WAIT) begin
         if (wait_q != '0) wait_d = wait_q - WAIT_ONE;
      end else if (state_q == SAMPLE) begin
         if (mismatch) begin
            err_d = err_q + ERR_ONE;
            if (!fail_q) begin
               fail_d = 1'b1;
               ffv_d  = vec_q;
            end
         end
         // The last vector never increments, so vec_o parks at all-ones in DONE.
         if (last_vec) begin
            pass_d = (err_d == '0);
         end else begin
            vec_d  = vec_q + VEC_ONE;
            wait_d = SETTLE_W;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wait_q <= '0;
         vec_q  <= '0;
         ffv_q  <= '0;
         err_q  <= '0;
         fail_q <= 1'b0;
         pass_q <= 1'b0;
      end else begin
         wait_q <= wait_d;
         vec_q  <= vec_d;
         ffv_q  <= ffv_d;
         err_q  <= err_d;
         fail_q <= fail_d;
         pass_q <= pass_d;
      end
   end

   assign vec_o          = vec_q;
   assign err_count      = err_q;
   assign fail_seen      = fail_q;
   assign first_fail_vec = ffv_q;
   assign pass           = pass_q;

endmodule

// File: tb/tb_gate_vector_checker.sv
// Bench for gate_vector_checker: AND/SETTLE=1 and XOR/SETTLE=0 instances against a timeline model.
module tb_gate_vector_checker;

   localparam int N  = 4;
   localparam int V  = 16;
   localparam int PA = 3;
   localparam int PB = 2;
   localparam int TA = V * PA;
   localparam int TB = V * PB;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic start_a = 1'b0;
   logic start_b = 1'b0;
   int   mode_a = 0;
   int   mode_b = 0;

   logic [N-1:0] vec_a, vec_b, ffv_a, ffv_b;
   logic [N:0]   err_a, err_b;
   logic         f_a, f_b;
   logic         busy_a, done_a, pass_a, sv_a, fs_a;
   logic         busy_b, done_b, pass_b, sv_b, fs_b;

   int checks = 0;
   int errors = 0;
   int sv_cnt_a = 0;
   bit cmp_en = 1'b0;

   always #5 clk = ~clk;

   // Lab DUTs: A is and4 / tied 0 / tied 1, B is xor4 / xnor4.
   always_comb begin
      f_a = (mode_a == 0) ? (&vec_a) : ((mode_a == 1) ? 1'b0 : 1'b1);
      f_b = (mode_b == 0) ? (^vec_b) : ~(^vec_b);
   end

   gate_vector_checker #(.N(N), .SETTLE(1), .OP(0)) dut_a (
      .clk(clk), .reset(reset), .start(start_a), .vec_o(vec_a), .dut_f_i(f_a),
      .busy(busy_a), .done(done_a), .pass(pass_a), .sample_valid(sv_a),
      .err_count(err_a), .fail_seen(fs_a), .first_fail_vec(ffv_a)
   );

   gate_vector_checker #(.N(N), .SETTLE(0), .OP(2)) dut_b (
      .clk(clk), .reset(reset), .start(start_b), .vec_o(vec_b), .dut_f_i(f_b),
      .busy(busy_b), .done(done_b), .pass(pass_b), .sample_valid(sv_b),
      .err_count(err_b), .fail_seen(fs_b), .first_fail_vec(ffv_b)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: j = edges elapsed since the accepted start edge; each vector takes p cycles.
   bit run_a = 0, run_b = 0;
   int ja = 0, jb = 0;
   logic [V-1:0] mis_a = '0, mis_b = '0;

   function automatic bit dut_a_out(input int m, input int v);
      return (m == 0) ? (v == 15) : (m == 2);
   endfunction

   function automatic bit parity(input int v);
      return ($countones(v[3:0]) % 2) == 1;
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         run_a = 0; ja = 0;
         run_b = 0; jb = 0;
      end else begin
         if ((!run_a || ja >= TA) && start_a) begin
            run_a = 1; ja = 0;
            for (int v = 0; v < V; v++) mis_a[v] = dut_a_out(mode_a, v) != (v == 15);
         end else if (run_a && ja < TA) ja++;
         if ((!run_b || jb >= TB) && start_b) begin
            run_b = 1; jb = 0;
            for (int v = 0; v < V; v++) mis_b[v] = ((mode_b == 0) ? parity(v) : !parity(v)) != parity(v);
         end else if (run_b && jb < TB) jb++;
      end
   end

   function automatic void expv(input bit run, input int j, input int p, input logic [V-1:0] mis,
                                output logic e_busy, output logic e_done, output logic e_pass,
                                output logic e_sv, output int e_vec, output int e_err,
                                output logic e_fs, output int e_ffv);
      int ns;
      e_busy = 0; e_done = 0; e_pass = 0; e_sv = 0;
      e_vec = 0; e_err = 0; e_fs = 0; e_ffv = 0;
      if (run) begin
         e_busy = j < V * p;
         e_done = !e_busy;
         e_sv   = e_busy && (j % p == p - 1);
         e_vec  = e_busy ? j / p : V - 1;
         ns     = (j / p > V) ? V : j / p;
         for (int v = 0; v < ns; v++) begin
            if (mis[v]) begin
               if (e_err == 0) e_ffv = v;
               e_err++;
            end
         end
         e_fs   = e_err > 0;
         e_pass = e_done && (e_err == 0);
      end
   endfunction

   always @(negedge clk) begin
      logic eb, ed, ep, es, ef;
      int ev, ee, eff;
      if (sv_a === 1'b1) sv_cnt_a++;
      if (cmp_en) begin
         expv(run_a, ja, PA, mis_a, eb, ed, ep, es, ev, ee, ef, eff);
         chk("a_busy", busy_a, eb); chk("a_done", done_a, ed); chk("a_pass", pass_a, ep);
         chk("a_sample_valid", sv_a, es); chk("a_vec", vec_a, ev); chk("a_err_count", err_a, ee);
         chk("a_fail_seen", fs_a, ef); chk("a_first_fail_vec", ffv_a, eff);
         expv(run_b, jb, PB, mis_b, eb, ed, ep, es, ev, ee, ef, eff);
         chk("b_busy", busy_b, eb); chk("b_done", done_b, ed); chk("b_pass", pass_b, ep);
         chk("b_sample_valid", sv_b, es); chk("b_vec", vec_b, ev); chk("b_err_count", err_b, ee);
         chk("b_fail_seen", fs_b, ef); chk("b_first_fail_vec", ffv_b, eff);
      end
   end

   task automatic pulse(input bit b);
      @(negedge clk); #1;
      if (b) start_b = 1'b1;
      else   start_a = 1'b1;
      @(posedge clk); #1;
      start_a = 1'b0;
      start_b = 1'b0;
   endtask

   task automatic wait_done(input bit b, output int n);
      n = 0;
      while (!(b ? done_b : done_a) && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 200) chk(b ? "b_done_timeout" : "a_done_timeout", 0, 1);
   endtask

   initial begin
      int n, m, k;
      repeat (2) @(negedge clk);
      cmp_en = 1'b1;
      chk("reset_vec", vec_a, 0);
      chk("reset_busy", busy_a, 0);
      #1 reset = 1'b0;

      // 1: and4 DUT passes
      mode_a = 0; sv_cnt_a = 0;
      pulse(0); wait_done(0, n);
      chk("t1_done_cycle", n, 48); chk("t1_err", err_a, 0); chk("t1_pass", pass_a, 1);
      chk("t1_fail_seen", fs_a, 0);
      @(negedge clk); chk("t1_strobes", sv_cnt_a, 16);

      // 2: tied 0
      mode_a = 1;
      pulse(0); wait_done(0, n);
      chk("t2_err", err_a, 1); chk("t2_fail_seen", fs_a, 1);
      chk("t2_ffv", ffv_a, 15); chk("t2_pass", pass_a, 0);

      // 3: tied 1
      mode_a = 2;
      pulse(0); wait_done(0, n);
      chk("t3_err", err_a, 15); chk("t3_ffv", ffv_a, 0); chk("t3_pass", pass_a, 0);

      // 4: reset mid-run at vec 7 in WAIT
      pulse(0);
      k = 0;
      while (!(vec_a == 7 && busy_a && !sv_a) && k < 100) begin
         @(posedge clk); #1; k++;
      end
      chk("t4_reach_vec7", vec_a, 7);
      chk("t4_err_pre", err_a, 7);
      reset = 1'b1; #1;
      chk("t4_vec", vec_a, 0); chk("t4_busy", busy_a, 0);
      chk("t4_err", err_a, 0); chk("t4_done", done_a, 0);
      @(negedge clk); #1 reset = 1'b0;
      mode_a = 0;
      pulse(0); wait_done(0, n);
      chk("t4_rerun_cycle", n, 48); chk("t4_rerun_pass", pass_a, 1);

      // 5: start while busy ignored; then restart from a failing DONE
      pulse(0);
      n = 0;
      repeat (10) begin @(posedge clk); #1; n++; end
      start_a = 1'b1;
      @(posedge clk); #1; n++;
      start_a = 1'b0;
      wait_done(0, m);
      chk("t5_done_cycle", n + m, 48);
      mode_a = 2;
      pulse(0); wait_done(0, n);
      chk("t5_fail_err", err_a, 15);
      mode_a = 0;
      pulse(0);
      chk("t5_restart_err", err_a, 0); chk("t5_restart_fs", fs_a, 0);
      chk("t5_restart_busy", busy_a, 1);
      wait_done(0, n);

      // start held high in DONE restarts back to back
      @(negedge clk); #1 start_a = 1'b1;
      repeat (100) @(posedge clk);
      #1 start_a = 1'b0;
      wait_done(0, n);
      chk("hold_pass", pass_a, 1);

      // 6: SETTLE=0 XOR instance, then XNOR DUT
      mode_b = 0;
      pulse(1); wait_done(1, n);
      chk("t6_done_cycle", n, 32); chk("t6_pass", pass_b, 1);
      mode_b = 1;
      pulse(1); wait_done(1, n);
      chk("t6_xnor_err", err_b, 16); chk("t6_xnor_pass", pass_b, 0);
      chk("t6_xnor_ffv", ffv_b, 0);

      repeat (3) @(negedge clk);
      cmp_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
